// File: rtl/wavegen_cmd_ctrl.sv
// Button-driven waveform select/divider controller feeding spi_master with {div, sel} packets.
// Define WAVEGEN_REFRESH_EN to resend the current packet every REFRESH_CYC cycles.
module wavegen_cmd_ctrl #(
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned NUM_MODES    = 4,
    parameter int unsigned INIT_SEL     = 1,
    parameter int unsigned INIT_DIV     = 250,
    parameter int unsigned DIV_MIN      = 10,
    parameter int unsigned DIV_MAX      = 65535,
    parameter int unsigned DIV_STEP     = 10,
    parameter int unsigned DEBOUNCE_CYC = 120000,
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned REFRESH_CYC  = 12000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_mode_n,
    input  logic                   btn_up_n,
    input  logic                   btn_down_n,
    input  logic                   spi_busy,
    output logic                   spi_send,
    output logic [DIV_W+SEL_W-1:0] spi_data,
    output logic [SEL_W-1:0]       cur_sel,
    output logic [DIV_W-1:0]       cur_div,
    output logic                   pending
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACK_TIMEOUT);
    localparam logic [DIV_W:0]   MAX_X   = (DIV_W+1)'(DIV_MAX);
    localparam logic [DIV_W:0]   MIN_X   = (DIV_W+1)'(DIV_MIN);
    localparam logic [DIV_W:0]   STEP_X  = (DIV_W+1)'(DIV_STEP);
    localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    // Bit 0 mode, bit 1 up, bit 2 down.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q, sync2_q, acc_q, press_q;
    logic [DB_W-1:0] db_cnt_q [3];

    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W:0]         div_up, div_dn;
    logic                   changed;

    state_t                 state_q;
    logic [TO_W-1:0]        timer_q;
    logic                   dirty_q, dirty_d, init_q, spi_send_q;
    logic [DIV_W+SEL_W-1:0] spi_data_q;
    logic                   latch, retry, refresh_hit;

    always_comb btn_raw = {btn_down_n, btn_up_n, btn_mode_n};

    // Counter runs only while the synchronised level disagrees with the accepted one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            acc_q   <= '1;
            press_q <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2_q[i] == acc_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_cnt_q[i] <= '0;
                    acc_q[i]    <= sync2_q[i];
                    press_q[i]  <= ~sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        sel_d  = sel_q;
        div_d  = div_q;
        div_up = {1'b0, div_q} + STEP_X;
        div_dn = {1'b0, div_q} - STEP_X;
        if (press_q[0])
            sel_d = (sel_q == SEL_TOP) ? '0 : sel_q + SEL_W'(1);
        if (press_q[1] && !press_q[2])
            div_d = (div_up > MAX_X) ? MAX_X[DIV_W-1:0] : div_up[DIV_W-1:0];
        else if (press_q[2] && !press_q[1])
            div_d = (({1'b0, div_q} < STEP_X) || (div_dn < MIN_X)) ? MIN_X[DIV_W-1:0]
                                                                    : div_dn[DIV_W-1:0];
        changed = (sel_d != sel_q) || (div_d != div_q);
    end

`ifdef WAVEGEN_REFRESH_EN
    localparam int unsigned RF_W = $clog2(REFRESH_CYC + 1);
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYC - 1);
    logic [RF_W-1:0] refresh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            refresh_q <= '0;
        else if (latch || refresh_q == RF_LAST)
            refresh_q <= '0;
        else
            refresh_q <= refresh_q + RF_W'(1);
    end

    always_comb refresh_hit = (refresh_q == RF_LAST);
`else
    always_comb refresh_hit = 1'b0;
`endif

    // Any set source wins over the clear on the latch cycle, so a late press is never lost.
    always_comb begin
        latch   = (state_q == IDLE) && dirty_q && !spi_busy;
        retry   = (state_q == WAIT_ACK) && !spi_busy && (timer_q == TO_LAST);
        dirty_d = dirty_q;
        if (latch)
            dirty_d = 1'b0;
        if (changed || init_q || retry || refresh_hit)
            dirty_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            dirty_q    <= 1'b0;
            init_q     <= 1'b1;
            spi_send_q <= 1'b0;
            spi_data_q <= '0;
            sel_q      <= SEL_W'(INIT_SEL);
            div_q      <= DIV_W'(INIT_DIV);
        end else begin
            sel_q      <= sel_d;
            div_q      <= div_d;
            dirty_q    <= dirty_d;
            init_q     <= 1'b0;
            spi_send_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (latch) begin
                        spi_data_q <= {div_q, sel_q};
                        spi_send_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    timer_q <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (spi_busy)
                        state_q <= WAIT_DONE;
                    else if (retry)
                        state_q <= IDLE;
                    else
                        timer_q <= timer_q + TO_W'(1);
                end
                WAIT_DONE: begin
                    if (!spi_busy)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        spi_send = spi_send_q;
        spi_data = spi_data_q;
        cur_sel  = sel_q;
        cur_div  = div_q;
        pending  = dirty_q;
    end

endmodule

// File: doc/wavegen_cmd_ctrl.md
# wavegen_cmd_ctrl

Parametrised command controller for the board-to-board waveform link. It debounces three active-low front-panel buttons to select a waveform mode and step a 16-bit frequency divider up and down. It coalesces changes and sends each settled `{divider, select}` packet exactly once through the existing SPI master using a send/busy handshake. It sits between the board switches and `spi_master`.

## Interface
- `SEL_W`, 2: waveform-select field width.
- `DIV_W`, 16: divider field width.
- `NUM_MODES`, 4: number of waveform modes (≤ 2^SEL_W).
- `INIT_SEL`, 1: select value after reset.
- `INIT_DIV`, 250: divider value after reset.
- `DIV_MIN` / `DIV_MAX` / `DIV_STEP`, 10 / 65535 / 10: divider limits and step size.
- `DEBOUNCE_CYC`, 120000: number of stable cycles a button needs before it is accepted (10 ms at 12 MHz).
- `ACK_TIMEOUT`, 64: number of cycles to wait for `spi_busy` to rise.
- `REFRESH_CYC`, 12000000: auto-refresh period (used only when `WAVEGEN_REFRESH_EN` is defined).
- `clk` in 1: 12 MHz system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_mode_n`, `btn_up_n`, `btn_down_n` in 1 each: raw active-low buttons, asynchronous to `clk`.
- `spi_busy` in 1: busy flag from the SPI master.
- `spi_send` out 1: single-cycle send strobe to the SPI master.
- `spi_data` out DIV_W+SEL_W: packet `{div, sel}`.
- `cur_sel` out SEL_W: current committed select value.
- `cur_div` out DIV_W: current committed divider value.
- `pending` out 1: a change is waiting to be sent.

## Operation
- **Button input:** each button passes through a 2-FF synchroniser, then a debouncer.
  - The debouncer counter resets whenever the synchronised level differs from the accepted level.
  - The accepted level flips when the counter reaches `DEBOUNCE_CYC-1`.
  - A "press" is a one-cycle pulse on the accepted 1→0 transition. Holding a button produces exactly one press.
- **Mode press:** `sel <= (sel == NUM_MODES-1) ? 0 : sel+1`.
- **Up press:** `div <= min(div+DIV_STEP, DIV_MAX)`. The addition is computed DIV_W+1 bits wide, so it cannot wrap.
- **Down press:** `div <= max(div-DIV_STEP, DIV_MIN)`. The result saturates and never underflows.
- **Up and down in the same cycle:** both are ignored. A mode press in that same cycle still applies.
- **Dirty flag:**
  - Any press that changes `sel` or `div` sets `dirty`.
  - A press that saturates with no value change does not set `dirty`.
  - `pending = dirty`.
- **FSM states:** IDLE, SEND, WAIT_ACK, WAIT_DONE.
  - IDLE: if `dirty && !spi_busy`, latch `spi_data <= {div, sel}`, clear `dirty`, go to SEND.
  - SEND: `spi_send = 1` for this one cycle; go to WAIT_ACK with the timer cleared.
  - WAIT_ACK: when `spi_busy` = 1, go to WAIT_DONE. If the timer reaches `ACK_TIMEOUT`, set `dirty` (retry) and go to IDLE.
  - WAIT_DONE: when `spi_busy` = 0, go to IDLE.
- **Stable packet:** `spi_data` changes only on the IDLE→SEND transition.
- **Changes during a transfer:** presses while in SEND, WAIT_ACK or WAIT_DONE update `sel`/`div` and set `dirty`. They are coalesced into a single follow-up packet.
- **Press on the latch cycle:** a press in the same cycle as the IDLE latch updates the value and re-sets `dirty`, so the newer value is sent next. Set has priority over clear.

## Timing
- **Reset values:**
  - `spi_send` = 0, `spi_data` = 0, `pending` = 0.
  - `cur_sel` = INIT_SEL, `cur_div` = INIT_DIV.
  - FSM in IDLE, debouncers accept level 1 (released).
  - One initial send is requested: `dirty` = 1 the first cycle after `rst` falls.
- **Press latency:** raw edge → press pulse is 2 synchroniser cycles + DEBOUNCE_CYC. Press pulse → `cur_*` updated takes 1 cycle.
- **Send latency:** `dirty` in IDLE with `spi_busy` = 0 → `spi_send` high 2 cycles later (latch, then SEND).
- All outputs are registered.
- **Reset mid-transfer:** the FSM returns to IDLE at once and `spi_send` drops. The SPI master is not aborted; the post-reset initial send waits in IDLE until `spi_busy` = 0.

## Configuration
- **`WAVEGEN_REFRESH_EN` defined:** a free-running counter sets `dirty` every `REFRESH_CYC` cycles, so the current packet is resent periodically. This recovers a receiver that has been reset. The counter restarts on every packet sent.
- **Not defined:** the counter is absent, and packets are sent only on change, on reset, and on timeout retry.

## Test plan
- **Reset:** deassert `rst` with `spi_busy` held 0 → exactly one `spi_send` pulse with `spi_data` = {16'd250, 2'b01}. Model busy high for 36 cycles after the pulse; afterwards `pending` = 0.
- **Mode cycling:** bounce `btn_mode_n` for 5 ms, then hold it low (DEBOUNCE_CYC set to 100 in the bench) → one press; `cur_sel` goes 1→2. Repeat three more times → 3, 0, 1. There is one packet per press.
- **Saturation:** `cur_div` = 65530 + up press → 65535 and a packet is sent. A further up press → no change, no `dirty`, no packet. A down press from 15 → 10; another → no change.
- **Coalescing:** 3 up presses while `spi_busy` = 1 → after busy falls, exactly one packet with div = 280.
- **Timeout retry:** `spi_busy` stuck at 0 → `spi_send` repeats every ACK_TIMEOUT+3 cycles with the identical packet.
- **Refresh (with `WAVEGEN_REFRESH_EN`, REFRESH_CYC = 1000):** idle → a packet every ~1000 cycles with unchanged data.
